// File: rtl/rom_loader.sv
// Byte-stream ROM writer: 4-byte big-endian length, payload, checksum byte.
// Keeps the core in reset (cpu_rst low) until a verified image is in place.
module rom_loader #(
  parameter int ROM_BYTES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          reload,
  output logic [0:ROM_BYTES-1][7:0]     rom,
  output logic                          cpu_rst,
  output logic                          done,
  output logic [1:0]                    err_code
);

  localparam int AW = (ROM_BYTES > 1) ? $clog2(ROM_BYTES) : 1;

  typedef enum logic [2:0] {LEN, DATA, SUM, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  len_cnt;
  logic [31:0] len;
  logic [31:0] cnt;
  logic [7:0]  sum;

  logic        xfer;
  logic [31:0] len_next;
  logic [7:0]  sum_next;

  assign xfer     = in_valid && in_ready;
  assign len_next = {len[23:0], in_data};
  assign sum_next = sum + in_data;

  // in_ready is registered: each branch sets it to whether the next state accepts bytes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= LEN;
      len_cnt  <= '0;
      len      <= '0;
      cnt      <= '0;
      sum      <= '0;
      rom      <= '0;
      in_ready <= 1'b0;
      cpu_rst  <= 1'b0;
      done     <= 1'b0;
      err_code <= 2'd0;
    end else begin
      case (state)
        LEN: begin
          in_ready <= 1'b1;
          if (xfer) begin
            len     <= len_next;
            len_cnt <= len_cnt + 2'd1;
            if (len_cnt == 2'd3) begin
              cnt <= '0;
              if (len_next > 32'(ROM_BYTES)) begin
                state    <= ERR;
                err_code <= 2'd1;
                in_ready <= 1'b0;
              end else if (len_next[1:0] != 2'b00) begin
                state    <= ERR;
                err_code <= 2'd2;
                in_ready <= 1'b0;
              end else if (len_next == 32'd0) begin
                state <= SUM;
              end else begin
                state <= DATA;
              end
            end
          end
        end

        DATA: begin
          in_ready <= 1'b1;
          if (xfer) begin
            rom[cnt[AW-1:0]] <= in_data;
            sum              <= sum_next;
            cnt              <= cnt + 32'd1;
            if (cnt == len - 32'd1)
              state <= SUM;
          end
        end

        SUM: begin
          in_ready <= 1'b1;
          if (xfer) begin
            in_ready <= 1'b0;
            if (sum_next == 8'd0) begin
              state   <= DONE;
              done    <= 1'b1;
              cpu_rst <= 1'b1;
            end else begin
              state    <= ERR;
              err_code <= 2'd3;
            end
          end
        end

        DONE, ERR: begin
          in_ready <= 1'b0;
          // rom deliberately kept: bytes above the next image's length survive
          if (reload) begin
            state    <= LEN;
            len_cnt  <= '0;
            len      <= '0;
            cnt      <= '0;
            sum      <= '0;
            done     <= 1'b0;
            cpu_rst  <= 1'b0;
            err_code <= 2'd0;
            in_ready <= 1'b1;
          end
        end

        default: begin
          state    <= LEN;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized bench for rom_loader; a stream-level model predicts rom, done and err_code.
module tb_rom_loader;
  localparam int ROM_BYTES = 64;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid;
  logic [7:0]                in_data;
  logic                      in_ready;
  logic                      reload;
  logic [0:ROM_BYTES-1][7:0] rom;
  logic                      cpu_rst;
  logic                      done;
  logic [1:0]                err_code;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_rom [ROM_BYTES];

  rom_loader #(.ROM_BYTES(ROM_BYTES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .reload(reload), .rom(rom), .cpu_rst(cpu_rst), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  // Reference: decide outcome of a whole stream and update the expected rom image.
  task automatic model_stream(input logic [7:0] s[$], output int consumed,
                              output logic exp_done, output logic [1:0] exp_err);
    int unsigned l;
    int sum;
    l = {s[0], s[1], s[2], s[3]};
    consumed = 4;
    exp_done = 1'b0;
    exp_err  = 2'd0;
    if (l > ROM_BYTES) exp_err = 2'd1;
    else if (l % 4 != 0) exp_err = 2'd2;
    else begin
      sum = 0;
      for (int i = 0; i < int'(l); i++) begin
        exp_rom[i] = s[4+i];
        sum += s[4+i];
      end
      consumed = 4 + int'(l) + 1;
      if (((sum + s[4+l]) % 256) == 0) exp_done = 1'b1;
      else exp_err = 2'd3;
    end
  endtask

  // Entered and left on a negedge; ok means the byte was taken by a posedge.
  task automatic send_byte(input logic [7:0] b, input int gap, input int wait_max, output bit ok);
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    for (int w = 0; w < wait_max && !ok; w++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_rom(input string name);
    int bad = 0;
    n_checks++;
    for (int i = 0; i < ROM_BYTES; i++)
      if (rom[i] !== exp_rom[i]) begin
        if (bad < 4) $display("FAIL %s rom[%0d] got %h want %h", name, i, rom[i], exp_rom[i]);
        bad++;
      end
    if (bad != 0) n_fail++;
  endtask

  task automatic run_image(input logic [7:0] s[$], input int max_gap, input int reload_at,
                           input string name);
    int cons, acc;
    logic ed;
    logic [1:0] ee;
    bit ok;
    logic [7:0] extra;
    model_stream(s, cons, ed, ee);
    acc = 0;
    for (int k = 0; k < cons; k++) begin
      if (k == reload_at) pulse_reload();
      send_byte(s[k], $urandom_range(max_gap, 0), 30, ok);
      if (!ok) break;
      acc++;
    end
    n_checks++;
    if (acc !== cons) begin
      n_fail++;
      $display("FAIL %s accepted got %0d want %0d", name, acc, cons);
    end
    n_checks++;
    if ({done, cpu_rst, err_code, in_ready} !== {ed, ed, ee, 1'b0}) begin
      n_fail++;
      $display("FAIL %s status done/cpu_rst/err/rdy got %b%b %0d %b want %b%b %0d 0",
               name, done, cpu_rst, err_code, in_ready, ed, ed, ee);
    end
    extra = (cons < s.size()) ? s[cons] : 8'h5a;
    send_byte(extra, 0, 3, ok);
    n_checks++;
    if (ok !== 1'b0) begin
      n_fail++;
      $display("FAIL %s trailing byte consumed got 1 want 0", name);
    end
    check_rom(name);
  endtask

  task automatic reload_and_check(input string name);
    pulse_reload();
    n_checks++;
    if ({done, cpu_rst, err_code, in_ready} !== 5'b00_00_1) begin
      n_fail++;
      $display("FAIL %s reload status got %b%b %0d %b want 00 0 1",
               name, done, cpu_rst, err_code, in_ready);
    end
  endtask

  function automatic void len_hdr(input int unsigned l, ref logic [7:0] s[$]);
    s.push_back(l[31:24]); s.push_back(l[23:16]); s.push_back(l[15:8]); s.push_back(l[7:0]);
  endfunction

  task automatic build_image(input int unsigned l, input bit good, output logic [7:0] s[$]);
    logic [7:0] sum = 8'd0;
    logic [7:0] b;
    s = {};
    len_hdr(l, s);
    if (l <= ROM_BYTES) begin
      for (int i = 0; i < int'(l); i++) begin
        b = 8'($urandom);
        s.push_back(b);
        sum += b;
      end
      s.push_back(good ? 8'(-sum) : 8'(-sum + 8'($urandom_range(255, 1))));
    end else begin
      for (int i = 0; i < 8; i++) s.push_back(8'($urandom));
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    foreach (exp_rom[i]) exp_rom[i] = 8'h00;
    n_checks++;
    if ({in_ready, cpu_rst, done, err_code} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset status got %b%b%b %0d want 000 0", in_ready, cpu_rst, done, err_code);
    end
    check_rom("reset");
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release in_ready got %b want 1", in_ready);
    end
  endtask

  logic [7:0] img1 [$];

  task automatic test_basic();
    run_image(img1, 0, -1, "basic");
  endtask

  task automatic test_gaps();
    reload_and_check("gaps");
    run_image(img1, 5, -1, "gaps");
  endtask

  task automatic test_len_errors();
    logic [7:0] s[$];
    reload_and_check("too_long");
    build_image(ROM_BYTES + 4, 1'b1, s);
    run_image(s, 2, -1, "too_long");
    reload_and_check("both_bad");
    build_image(ROM_BYTES + 5, 1'b1, s);
    run_image(s, 0, -1, "both_bad");
    reload_and_check("mod4");
    s = {}; len_hdr(6, s);
    for (int i = 0; i < 7; i++) s.push_back(8'($urandom));
    run_image(s, 1, -1, "mod4");
    reload_and_check("zero_len");
    s = {}; len_hdr(0, s); s.push_back(8'h00);
    run_image(s, 1, -1, "zero_len");
  endtask

  task automatic test_bad_checksum();
    logic [7:0] s[$];
    reload_and_check("bad_chk");
    s = img1;
    s[12] = 8'h99;
    run_image(s, 0, -1, "bad_chk");
    reload_and_check("after_bad_chk");
    run_image(img1, 1, -1, "after_bad_chk");
  endtask

  task automatic test_reload_ignored();
    reload_and_check("reload_mid");
    run_image(img1, 1, 6, "reload_mid");
  endtask

  task automatic test_reset_midload();
    bit ok;
    reload_and_check("rst_mid");
    for (int k = 0; k < 7; k++) send_byte(img1[k], 0, 30, ok);
    test_reset();
    run_image(img1, 2, -1, "rst_mid_reload");
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    int unsigned l;
    for (int it = 0; it < 12; it++) begin
      reload_and_check("random");
      case ($urandom_range(5, 0))
        0:       l = ROM_BYTES + 1 + $urandom_range(200, 0);
        1:       l = 4 * $urandom_range(ROM_BYTES / 4 - 1, 0) + $urandom_range(3, 1);
        default: l = 4 * $urandom_range(ROM_BYTES / 4, 0);
      endcase
      build_image(l, $urandom_range(3, 0) != 0, s);
      run_image(s, $urandom_range(3, 0), -1, "random");
    end
  endtask

  initial begin
    in_valid = 1'b0;
    in_data  = 8'h00;
    reload   = 1'b0;
    img1 = '{8'h00, 8'h00, 8'h00, 8'h08,
             8'h24, 8'h08, 8'h00, 8'h05, 8'h24, 8'h09, 8'h00, 8'h0A, 8'h98};
    @(negedge clk);
    test_reset();
    test_basic();
    test_gaps();
    test_len_errors();
    test_bad_checksum();
    test_reload_ignored();
    test_reset_midload();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
